// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared types and constants for the program memory fetch block
// Contents:
//   state_t       : INIT (fill memory) / RUN (serve fetches and loads)
//   DEF_FILL_WORD : default init pattern (HALT opcode)
//   DEF_NOP_WORD  : default instruction returned on an error response
//   rsp_t         : response record {instr, addr, err} carried by the response FIFO
package prog_mem_pkg;

    localparam int RSP_DATA_W = 32;
    localparam int RSP_ADDR_W = 5;

    localparam logic [31:0] DEF_FILL_WORD = 32'h0000_0055;
    localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] instr;
        logic [RSP_ADDR_W-1:0] addr;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/prog_mem_rsp_fifo.sv
// rtl/prog_mem_rsp_fifo.sv - two-entry synchronous response FIFO with flush
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_flush    : empty the FIFO this cycle (wins over push/pop)
//   i_push     : write i_data at the tail
//   i_data     : response record to store
//   i_pop      : retire the head entry
//   o_head     : head entry (registered storage, no path from inputs)
//   o_count    : number of valid entries (0..2)
module prog_mem_rsp_fifo
    import prog_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_flush,
    input  logic       i_push,
    input  rsp_t       i_data,
    input  logic       i_pop,
    output rsp_t       o_head,
    output logic [1:0] o_count
);

    rsp_t       r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/prog_mem_fetch.sv
// rtl/prog_mem_fetch.sv - loadable instruction memory with valid/ready fetch port and response buffer
// Optional feature macro: PROG_MEM_PARITY_EN (stores an even-parity bit per word, checked on fetch)
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   i_req_valid/o_req_ready/i_req_addr : fetch request handshake and address
//   o_rsp_valid/i_rsp_ready            : response handshake (head of 2-entry FIFO)
//   o_rsp_instr/o_rsp_addr/o_rsp_err   : fetched word, its address, range/parity error
//   i_flush                            : drop buffered responses and this cycle's fetch
//   i_ld_en/i_ld_addr/i_ld_data        : runtime load port, o_ld_ready when accepted
//   o_init_done                        : memory fill finished
//   o_par_err                          : sticky parity error flag
module prog_mem_fetch
    import prog_mem_pkg::*;
#(
    parameter int                DATA_W    = RSP_DATA_W,
    parameter int                ADDR_W    = RSP_ADDR_W,
    parameter int                DEPTH     = 32,
    parameter logic [DATA_W-1:0] FILL_WORD = DEF_FILL_WORD,
    parameter logic [DATA_W-1:0] NOP_WORD  = DEF_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_instr,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic              o_rsp_err,
    input  logic              i_flush,
    input  logic              i_ld_en,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_ld_ready,
    output logic              o_init_done,
    output logic              o_par_err
);

`ifdef PROG_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    function automatic logic [MEM_W-1:0] f_encode(input logic [DATA_W-1:0] d);
`ifdef PROG_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // No reset on the array: INIT is the only thing that defines its contents.
    logic [MEM_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    logic              w_run;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [MEM_W-1:0]  w_wdata;
    logic              w_ld_in_range;
    logic              w_rd_in_range;
    logic [MEM_W-1:0]  w_rd_word;
    logic              w_par_bad;
    logic              w_pop;
    logic [1:0]        w_count;
    logic [1:0]        w_count_after_pop;
    logic              w_accept;
    logic              w_push;
    rsp_t              w_push_data;
    rsp_t              w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_run       = (r_state == ST_RUN);
    assign o_init_done = w_run;
    assign o_ld_ready  = w_run;

    // Single write port shared by the init fill and the runtime load.
    assign w_ld_in_range = ({1'b0, i_ld_addr} < DEPTH_L);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_cnt;
        w_wdata = f_encode(FILL_WORD);
        if (!w_run) begin
            w_we = 1'b1;
        end else if (i_ld_en && w_ld_in_range) begin
            w_we    = 1'b1;
            w_waddr = i_ld_addr;
            w_wdata = f_encode(i_ld_data);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // The read is combinational in the accept cycle; its result lands in the
    // FIFO at the closing edge, so rsp_valid follows one cycle after accept.
    assign w_rd_in_range = ({1'b0, i_req_addr} < DEPTH_L);
    assign w_rd_word     = w_rd_in_range ? r_mem[i_req_addr] : f_encode(NOP_WORD);

`ifdef PROG_MEM_PARITY_EN
    assign w_par_bad = w_rd_in_range && (^w_rd_word);
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_pop             = (w_count != 2'd0) && i_rsp_ready;
    assign w_count_after_pop = w_count - {1'b0, w_pop};
    assign o_req_ready       = w_run && !i_ld_en && (w_count_after_pop <= 2'd1);
    assign w_accept          = i_req_valid && o_req_ready;
    assign w_push            = w_accept && !i_flush;

    assign w_push_data.instr = RSP_DATA_W'(w_rd_in_range ? w_rd_word[DATA_W-1:0] : NOP_WORD);
    assign w_push_data.addr  = RSP_ADDR_W'(i_req_addr);
    assign w_push_data.err   = !w_rd_in_range || w_par_bad;

    prog_mem_rsp_fifo u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (i_flush),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign o_rsp_valid = (w_count != 2'd0);
    assign o_rsp_instr = DATA_W'(w_head.instr);
    assign o_rsp_addr  = ADDR_W'(w_head.addr);
    assign o_rsp_err   = w_head.err;

`ifdef PROG_MEM_PARITY_EN
    logic r_par_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else if (w_push && w_par_bad) begin
            r_par_err <= 1'b1;
        end
    end
    assign o_par_err = r_par_err;
`else
    assign o_par_err = 1'b0;
`endif

endmodule
